// File: rtl/ddr2_read_burst_sequencer.sv
// DDR2 read-capture sequencer: CAS wait, ring-buffer arm pulse, 8-beat capture, valid/ready drain.
// Optional drain-stall watchdog with drain_timeout output: define DDR2_RDSEQ_WDOG_EN.
module ddr2_read_burst_sequencer #(
    parameter int DATA_W      = 16,
    parameter int TAG_W       = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [TAG_W-1:0]  rd_tag,
    input  logic [3:0]        cfg_cl,
    output logic              rb_listen,
    output logic [2:0]        rb_read_ptr,
    input  logic [DATA_W-1:0] rb_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_last,
`ifdef DDR2_RDSEQ_WDOG_EN
    output logic              drain_timeout,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CL,
        S_LISTEN,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cl_cnt_q, cl_cnt_d;
    logic [2:0]         cap_cnt_q, cap_cnt_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

`ifdef DDR2_RDSEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cl_cnt_q  <= '0;
            cap_cnt_q <= '0;
            ptr_q     <= '0;
            tag_q     <= '0;
`ifdef DDR2_RDSEQ_WDOG_EN
            wdog_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cl_cnt_q  <= cl_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            ptr_q     <= ptr_d;
            tag_q     <= tag_d;
`ifdef DDR2_RDSEQ_WDOG_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cl_cnt_d  = cl_cnt_q;
        cap_cnt_d = cap_cnt_q;
        ptr_d     = ptr_q;
        tag_d     = tag_q;
`ifdef DDR2_RDSEQ_WDOG_EN
        wdog_d        = '0;
        drain_timeout = 1'b0;
`endif
        rd_ready    = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        rb_listen   = (state_q == S_LISTEN);
        out_valid   = (state_q == S_DRAIN);
        out_last    = (state_q == S_DRAIN) && (ptr_q == 3'd7);
        out_data    = rb_dout;
        out_tag     = tag_q;
        rb_read_ptr = ptr_q;

        unique case (state_q)
            S_IDLE: begin
                if (rd_valid) begin
                    tag_d    = rd_tag;
                    // A CAS latency of zero is treated as one so LISTEN is always reached.
                    cl_cnt_d = (cfg_cl == 4'd0) ? 4'd1 : cfg_cl;
                    state_d  = S_WAIT_CL;
                end
            end
            S_WAIT_CL: begin
                cl_cnt_d = cl_cnt_q - 4'd1;
                if (cl_cnt_q == 4'd1) begin
                    state_d = S_LISTEN;
                end
            end
            S_LISTEN: begin
                cap_cnt_d = 3'd0;
                state_d   = S_CAPTURE;
            end
            S_CAPTURE: begin
                cap_cnt_d = cap_cnt_q + 3'd1;
                if (cap_cnt_q == 3'd7) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    // Pointer wraps 7 -> 0 on the last handshake, ready for the next burst.
                    ptr_d = ptr_q + 3'd1;
                    if (ptr_q == 3'd7) begin
                        state_d = S_IDLE;
                    end
`ifdef DDR2_RDSEQ_WDOG_EN
                end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    drain_timeout = 1'b1;
                    ptr_d         = 3'd0;
                    state_d       = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr2_read_burst_sequencer.sv
// Self-checking bench for ddr2_read_burst_sequencer; timing expectations derived from CAS latency arithmetic.
module tb_ddr2_read_burst_sequencer;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
`ifdef DDR2_RDSEQ_WDOG_EN
    localparam int WDOG   = 4;
`else
    localparam int WDOG   = 64;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_valid;
    logic              rd_ready;
    logic [TAG_W-1:0]  rd_tag;
    logic [3:0]        cfg_cl;
    logic              rb_listen;
    logic [2:0]        rb_read_ptr;
    logic [DATA_W-1:0] rb_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_last;
    logic              busy;
`ifdef DDR2_RDSEQ_WDOG_EN
    logic              drain_timeout;
`endif

    logic [DATA_W-1:0] mem [8];
    int n_vec = 0;
    int n_err = 0;

    assign rb_dout = mem[rb_read_ptr];

    always #5 clk = ~clk;

    ddr2_read_burst_sequencer #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_tag(rd_tag), .cfg_cl(cfg_cl),
        .rb_listen(rb_listen), .rb_read_ptr(rb_read_ptr), .rb_dout(rb_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_last(out_last),
`ifdef DDR2_RDSEQ_WDOG_EN
        .drain_timeout(drain_timeout),
`endif
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic chk_idle();
        chk("idle_rd_ready", 32'(rd_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_listen", 32'(rb_listen), 0);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_ptr", 32'(rb_read_ptr), 0);
        chk("idle_out_last", 32'(out_last), 0);
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0,..., 2 random ready, 3 two words then stall
    task automatic burst(input logic [3:0] tag, input logic [3:0] cl, input int mode,
                         input bit hold, input logic [3:0] next_tag, input bit fixed_data);
        int  eff, idx, stall, c;
        bit  done, rdy, drain, exp_to;
        for (int i = 0; i < 8; i++)
            mem[i] = fixed_data ? DATA_W'(16'hA000 + i) : DATA_W'($urandom);
        rd_valid = 1'b1;
        rd_tag   = tag;
        cfg_cl   = cl;
        #1;
        chk("pre_accept_rd_ready", 32'(rd_ready), 1);
        @(posedge clk); #1;
        eff    = (cl == 4'd0) ? 1 : int'(cl);
        cfg_cl = 4'($urandom);
        if (hold) rd_tag = next_tag;
        else      rd_valid = 1'b0;
        idx = 0; stall = 0; c = 0; done = 1'b0;
        for (int k = 0; k < eff + 9 + 300 && !done; k++) begin
            drain = (k >= eff + 9);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 3 == 0);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (idx < 2);
            endcase
            out_ready = rdy;
            #1;
            exp_to = drain && !rdy && (stall + 1 == WDOG);
            chk("busy_rd_ready", 32'(rd_ready), 0);
            chk("busy_busy", 32'(busy), 1);
            chk("listen", 32'(rb_listen), 32'(k == eff));
            chk("out_valid", 32'(out_valid), 32'(drain));
            chk("read_ptr", 32'(rb_read_ptr), drain ? 32'(idx) : 0);
            chk("out_tag", 32'(out_tag), 32'(tag));
            chk("out_last", 32'(out_last), 32'(drain && idx == 7));
            if (drain) chk("out_data", 32'(out_data), 32'(mem[idx]));
`ifdef DDR2_RDSEQ_WDOG_EN
            chk("drain_timeout", 32'(drain_timeout), 32'(exp_to));
`endif
            if (drain) begin
                if (rdy) begin
                    idx++; stall = 0;
                    if (idx == 8) done = 1'b1;
                end else begin
                    stall++;
                    if (exp_to) done = 1'b1;
                end
                c++;
            end
            @(posedge clk); #1;
        end
        chk("burst_completed", 32'(done), 1);
        out_ready = 1'($urandom);
        #1;
        chk_idle();
`ifdef DDR2_RDSEQ_WDOG_EN
        chk("idle_timeout", 32'(drain_timeout), 0);
`endif
    endtask

    initial begin
        reset     = 1'b1;
        rd_valid  = 1'b0;
        rd_tag    = '0;
        cfg_cl    = 4'd3;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk_idle();
            chk("reset_out_tag", 32'(out_tag), 0);
        end

        burst(4'h5, 4'd3, 0, 1'b0, 4'h0, 1'b1);
        burst(4'hC, 4'd0, 0, 1'b0, 4'h0, 1'b0);
        burst(4'h7, 4'd3, 1, 1'b0, 4'h0, 1'b1);
        burst(4'h2, 4'd5, 0, 1'b1, 4'hB, 1'b0);
        burst(4'hB, 4'd1, 2, 1'b0, 4'h0, 1'b0);
        for (int n = 0; n < 6; n++)
            burst(4'($urandom), 4'($urandom), 2, 1'b0, 4'h0, 1'b0);

        // reset in the middle of CAPTURE abandons the burst
        rd_valid = 1'b1; rd_tag = 4'h9; cfg_cl = 4'd2; out_ready = 1'b1;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("capture_busy", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle();
        chk("mid_reset_out_tag", 32'(out_tag), 0);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            chk("post_reset_out_valid", 32'(out_valid), 0);
            chk("post_reset_ptr", 32'(rb_read_ptr), 0);
        end

`ifdef DDR2_RDSEQ_WDOG_EN
        burst(4'h3, 4'd2, 3, 1'b0, 4'h0, 1'b0);
`endif
        burst(4'hE, 4'd15, 1, 1'b0, 4'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
